// File: rtl/pong_pkg.sv
// Purpose: shared types and default constants for the pong ball engine.
//   game_state_t : IDLE/PLAY/HOLD/OVER encoding exported on the state port
//   *_DEF        : default screen and paddle geometry
//   POS_W/ARITH_W/SCORE_W/STATE_W : port and internal arithmetic widths
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } game_state_t;

  localparam int unsigned H_RES_DEF     = 640;
  localparam int unsigned V_RES_DEF     = 480;
  localparam int unsigned BALL_SIZE_DEF = 8;
  localparam int unsigned PADDLE_W_DEF  = 10;
  localparam int unsigned PADDLE_H_DEF  = 50;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned ARITH_W = 11;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned STATE_W = 2;

endpackage

// File: rtl/pong_ball_engine_if.sv
// Purpose: game-side signal bundle of the pong ball engine.
//   frame_tick, serve, p1_y, p2_y   : inputs to the engine
//   ball_x, ball_y, score_p1/p2,
//   state, point_pulse, hit_pulse   : outputs of the engine
// master = game/controller side, slave = engine side.
interface pong_ball_engine_if;
  import pong_pkg::*;

  logic                 frame_tick;
  logic                 serve;
  logic [POS_W-1:0]     p1_y;
  logic [POS_W-1:0]     p2_y;
  logic [POS_W-1:0]     ball_x;
  logic [POS_W-1:0]     ball_y;
  logic [SCORE_W-1:0]   score_p1;
  logic [SCORE_W-1:0]   score_p2;
  logic [STATE_W-1:0]   state;
  logic                 point_pulse;
  logic                 hit_pulse;

  modport master (
    output frame_tick, serve, p1_y, p2_y,
    input  ball_x, ball_y, score_p1, score_p2, state, point_pulse, hit_pulse
  );

  modport slave (
    input  frame_tick, serve, p1_y, p2_y,
    output ball_x, ball_y, score_p1, score_p2, state, point_pulse, hit_pulse
  );

endinterface

// File: rtl/pong_paddle_hit.sv
// Purpose: combinational vertical-overlap test between ball and one paddle.
//   ball_y   : ball top row
//   paddle_y : paddle top row
//   overlap  : 1 when the ball rows intersect the paddle rows
module pong_paddle_hit
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE = BALL_SIZE_DEF,
  parameter int unsigned PADDLE_H  = PADDLE_H_DEF
) (
  input  logic [POS_W-1:0] ball_y,
  input  logic [POS_W-1:0] paddle_y,
  output logic             overlap
);

  logic [ARITH_W-1:0] by;
  logic [ARITH_W-1:0] py;

  // Widened so bottom-edge sums cannot wrap.
  assign by = ARITH_W'(ball_y);
  assign py = ARITH_W'(paddle_y);

  assign overlap = ((by + ARITH_W'(BALL_SIZE)) > py) && (by < (py + ARITH_W'(PADDLE_H)));

endmodule

// File: rtl/pong_ball_engine.sv
// Purpose: pong ball motion, paddle collision, scoring and game-state FSM.
//   CLOCK_50 : system clock
//   RESET_N  : asynchronous active-low reset
//   bus      : pong_ball_engine_if.slave (frame_tick, serve, paddle rows in;
//              ball position, scores, state and event pulses out, all registered)
// Optional feature: define PONG_SPEEDUP_EN to speed the ball up by one pixel
// per paddle hit, saturating at PADDLE_W-1.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int unsigned H_RES       = H_RES_DEF,
  parameter int unsigned V_RES       = V_RES_DEF,
  parameter int unsigned BALL_SIZE   = BALL_SIZE_DEF,
  parameter int unsigned PADDLE_W    = PADDLE_W_DEF,
  parameter int unsigned PADDLE_H    = PADDLE_H_DEF,
  parameter int unsigned SPEED_INIT  = 1,
  parameter int unsigned SCORE_MAX   = 9,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  pong_ball_engine_if.slave bus
);

  localparam int unsigned HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [ARITH_W-1:0] CX     = ARITH_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [ARITH_W-1:0] CY     = ARITH_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [ARITH_W-1:0] X_MAX  = ARITH_W'(H_RES - BALL_SIZE);
  localparam logic [ARITH_W-1:0] Y_MAX  = ARITH_W'(V_RES - BALL_SIZE);
  localparam logic [ARITH_W-1:0] X_L    = ARITH_W'(PADDLE_W);
  localparam logic [ARITH_W-1:0] X_R    = ARITH_W'(H_RES - PADDLE_W - BALL_SIZE);
  localparam logic [ARITH_W-1:0] V_INIT = ARITH_W'(SPEED_INIT);
`ifdef PONG_SPEEDUP_EN
  localparam logic [ARITH_W-1:0] V_MAX  = ARITH_W'(PADDLE_W - 1);
`endif

  game_state_t          state_q, state_d;
  logic [POS_W-1:0]     bx_q, by_q;
  logic [ARITH_W-1:0]   nx, ny;
  logic [ARITH_W-1:0]   bx, by;
  logic [SCORE_W-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic                 dx_q, dx_d;   // 1 = moving right
  logic                 dy_q, dy_d;   // 1 = moving down
  logic [ARITH_W-1:0]   v_q, v_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 hit_q, hit_d;
  logic                 point_q, point_d;
  logic                 miss_l, miss_r;
  logic                 ov1, ov2;

  assign bx = ARITH_W'(bx_q);
  assign by = ARITH_W'(by_q);

  pong_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)) u_hit_p1 (
    .ball_y   (by_q),
    .paddle_y (bus.p1_y),
    .overlap  (ov1)
  );

  pong_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)) u_hit_p2 (
    .ball_y   (by_q),
    .paddle_y (bus.p2_y),
    .overlap  (ov2)
  );

  // Next-state and next-output logic; everything advances only on frame_tick.
  always_comb begin
    state_d = state_q;
    nx      = bx;
    ny      = by;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    v_d     = v_q;
    hold_d  = hold_q;
    hit_d   = 1'b0;
    point_d = 1'b0;
    miss_l  = 1'b0;
    miss_r  = 1'b0;

    if (bus.frame_tick) begin
      unique case (state_q)
        IDLE: begin
          nx = CX;
          ny = CY;
          // dx is kept: it still points at whoever lost the last point.
          if (bus.serve) begin
            state_d = PLAY;
            v_d     = V_INIT;
            dy_d    = 1'b1;
          end
        end

        PLAY: begin
          // Vertical: clamp onto the wall and reverse.
          if (dy_q) begin
            if ((by + v_q) >= Y_MAX) begin
              ny   = Y_MAX;
              dy_d = 1'b0;
            end else begin
              ny = by + v_q;
            end
          end else if (by < v_q) begin
            ny   = '0;
            dy_d = 1'b1;
          end else begin
            ny = by - v_q;
          end

          // Horizontal: paddle face takes priority over the goal line.
          if (!dx_q) begin
            if ((bx < (X_L + v_q)) && ov1) begin
              nx    = X_L;
              dx_d  = 1'b1;
              hit_d = 1'b1;
            end else if (bx < v_q) begin
              miss_l = 1'b1;
            end else begin
              nx = bx - v_q;
            end
          end else begin
            if (((bx + v_q) > X_R) && ov2) begin
              nx    = X_R;
              dx_d  = 1'b0;
              hit_d = 1'b1;
            end else if ((bx + v_q) > X_MAX) begin
              miss_r = 1'b1;
            end else begin
              nx = bx + v_q;
            end
          end

          if (miss_l || miss_r) begin
            state_d = HOLD;
            hold_d  = '0;
            point_d = 1'b1;
            nx      = CX;
            ny      = CY;
            if (miss_l) begin
              s2_d = s2_q + SCORE_W'(1);
            end else begin
              s1_d = s1_q + SCORE_W'(1);
            end
          end

`ifdef PONG_SPEEDUP_EN
          if (hit_d && (v_q < V_MAX)) begin
            v_d = v_q + ARITH_W'(1);
          end
`endif
        end

        HOLD: begin
          nx = CX;
          ny = CY;
          if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
            hold_d = '0;
            if ((s1_q == SCORE_W'(SCORE_MAX)) || (s2_q == SCORE_W'(SCORE_MAX))) begin
              state_d = OVER;
            end else begin
              state_d = IDLE;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end

        OVER: begin
          nx = CX;
          ny = CY;
          if (bus.serve) begin
            s1_d    = '0;
            s2_d    = '0;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      bx_q    <= POS_W'(CX);
      by_q    <= POS_W'(CY);
      s1_q    <= '0;
      s2_q    <= '0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      v_q     <= V_INIT;
      hold_q  <= '0;
      hit_q   <= 1'b0;
      point_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= POS_W'(nx);
      by_q    <= POS_W'(ny);
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      v_q     <= v_d;
      hold_q  <= hold_d;
      hit_q   <= hit_d;
      point_q <= point_d;
    end
  end

  assign bus.ball_x      = bx_q;
  assign bus.ball_y      = by_q;
  assign bus.score_p1    = s1_q;
  assign bus.score_p2    = s2_q;
  assign bus.state       = state_q;
  assign bus.point_pulse = point_q;
  assign bus.hit_pulse   = hit_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Purpose: self-checking bench for pong_ball_engine (default geometry).
// Directed vector table replayed tick by tick, plus hand sequences for
// mid-play reset, ball speed after paddle hits (PONG_SPEEDUP_EN aware)
// and a full game to OVER.
module tb_pong_ball_engine;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pong_ball_engine_if bus();

  pong_ball_engine dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

`ifdef PONG_SPEEDUP_EN
  localparam int EXP_STEP = 4;
`else
  localparam int EXP_STEP = 1;
`endif

  // n ticks applied with serve/p1/p2, then expected outputs.
  typedef struct {
    int n; int serve; int p1; int p2;
    int x; int y; int st; int s1; int s2; int hit; int pt;
  } vec_t;

  vec_t vecs [22];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int x, input int y, input int st,
                           input int s1, input int s2, input int hit, input int pt);
    check({name, "_x"},     int'(bus.ball_x),      x);
    check({name, "_y"},     int'(bus.ball_y),      y);
    check({name, "_state"}, int'(bus.state),       st);
    check({name, "_s1"},    int'(bus.score_p1),    s1);
    check({name, "_s2"},    int'(bus.score_p2),    s2);
    check({name, "_hit"},   int'(bus.hit_pulse),   hit);
    check({name, "_point"}, int'(bus.point_pulse), pt);
  endtask

  // One frame tick; returns on the following falling edge with outputs settled.
  task automatic tick(input int s);
    @(negedge clk);
    bus.serve      = 1'(s);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic run_vec(input int i);
    bus.p1_y = 10'(vecs[i].p1);
    bus.p2_y = 10'(vecs[i].p2);
    for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].serve);
    check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].st,
              vecs[i].s1, vecs[i].s2, vecs[i].hit, vecs[i].pt);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Paddles follow the ball so every arrival is a hit; then measure one step.
  task automatic speed_seq();
    int hits = 0;
    int guard = 0;
    int x0, x1;
    tick(1);
    while (hits < 3 && guard < 3000) begin
      bus.p1_y = bus.ball_y;
      bus.p2_y = bus.ball_y;
      tick(0);
      guard++;
      if (bus.hit_pulse) hits++;
    end
    check("speed_hits", hits, 3);
    x0 = int'(bus.ball_x);
    tick(0);
    x1 = int'(bus.ball_x);
    check("speed_step", (x0 > x1) ? (x0 - x1) : (x1 - x0), EXP_STEP);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.serve      = 1'b0;
    bus.p1_y       = '0;
    bus.p2_y       = '0;

    // Rally 1: serve, floor bounce, P2 hit, ceiling bounce, P1 hit.
    vecs[0]  = '{0,   0, 0,   380, 316, 236, 0, 0, 0, 0, 0};
    vecs[1]  = '{1,   1, 0,   380, 316, 236, 1, 0, 0, 0, 0};
    vecs[2]  = '{1,   0, 0,   380, 317, 237, 1, 0, 0, 0, 0};
    vecs[3]  = '{234, 0, 0,   380, 551, 471, 1, 0, 0, 0, 0};
    vecs[4]  = '{1,   0, 0,   380, 552, 472, 1, 0, 0, 0, 0};
    vecs[5]  = '{1,   0, 0,   380, 553, 471, 1, 0, 0, 0, 0};
    vecs[6]  = '{69,  0, 0,   380, 622, 402, 1, 0, 0, 0, 0};
    vecs[7]  = '{1,   0, 0,   380, 622, 401, 1, 0, 0, 1, 0};
    vecs[8]  = '{1,   0, 0,   380, 621, 400, 1, 0, 0, 0, 0};
    vecs[9]  = '{400, 0, 0,   380, 221, 0,   1, 0, 0, 0, 0};
    vecs[10] = '{1,   0, 0,   380, 220, 0,   1, 0, 0, 0, 0};
    vecs[11] = '{1,   0, 0,   380, 219, 1,   1, 0, 0, 0, 0};
    vecs[12] = '{210, 0, 200, 380, 10,  211, 1, 0, 0, 1, 0};
    vecs[13] = '{1,   0, 200, 380, 11,  212, 1, 0, 0, 0, 0};
    // Rally 2 (after reset): P2 hit, P1 miss, hold, serve back toward P1.
    vecs[14] = '{1,   1, 0,   380, 316, 236, 1, 0, 0, 0, 0};
    vecs[15] = '{307, 0, 0,   380, 622, 401, 1, 0, 0, 1, 0};
    vecs[16] = '{622, 0, 0,   380, 0,   220, 1, 0, 0, 0, 0};
    vecs[17] = '{1,   0, 0,   380, 316, 236, 2, 0, 1, 0, 1};
    vecs[18] = '{59,  1, 0,   380, 316, 236, 2, 0, 1, 0, 0};
    vecs[19] = '{1,   0, 0,   380, 316, 236, 0, 0, 1, 0, 0};
    vecs[20] = '{1,   1, 0,   380, 316, 236, 1, 0, 1, 0, 0};
    vecs[21] = '{1,   1, 0,   380, 315, 237, 1, 0, 1, 0, 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

`ifndef PONG_SPEEDUP_EN
    for (int i = 0; i < 14; i++) run_vec(i);
`endif

    // Asynchronous reset in the middle of play.
    tick(1);
    repeat (5) tick(0);
    check("pre_reset_state", int'(bus.state), 1);
    #2 rst_n = 1'b0;
    #1 check_all("mid_play_reset", 316, 236, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef PONG_SPEEDUP_EN
    for (int i = 14; i < 22; i++) run_vec(i);
`endif

    pulse_reset();
    speed_seq();
    pulse_reset();

    // Full game: P2 misses nine times.
    for (int r = 1; r <= 9; r++) begin
      bus.p1_y = '0;
      bus.p2_y = '0;
      tick(1);
      repeat (317) tick(0);
      check($sformatf("game%0d_s1", r), int'(bus.score_p1), r);
      check($sformatf("game%0d_point", r), int'(bus.point_pulse), 1);
      check($sformatf("game%0d_hold", r), int'(bus.state), 2);
      repeat (60) tick(0);
      check($sformatf("game%0d_after_hold", r), int'(bus.state), (r == 9) ? 3 : 0);
    end
    check("over_s2", int'(bus.score_p2), 0);
    tick(0);
    check("over_stays", int'(bus.state), 3);
    tick(1);
    check_all("over_serve", 316, 236, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
